alu_core: RTL and testbench

- 16-bit two-operand ALU for the datapath of the simple RISC CPU.
- Computes ADD, SUB, AND or NOT-B, selected by a 2-bit opcode.
- Result and 3-bit status (zero, negative, overflow) are combinational.
- A clocked status register holds the last status for downstream branch/compare logic.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_flags.sv | 35 +++
 rtl/alu_core.sv | 81 ++++++++
 tb/tb_alu_core.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_core datapath ALU: opcode encodings and status bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  localparam int unsigned Z_ZERO = 0;
  localparam int unsigned Z_NEG  = 1;
  localparam int unsigned Z_OVF  = 2;
  localparam int unsigned Z_W    = 3;

endpackage

// File: rtl/alu_flags.sv
// Status flag generator for alu_core: zero, negative and overflow/borrow from the selected result.
module alu_flags
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]   res_i,
  input  logic           a_msb_i,
  input  logic           b_msb_i,
  input  logic           borrow_i,
  input  logic [1:0]     op_i,
  output logic [Z_W-1:0] z_o
);

  logic ovf;

  // The overflow bit is op-dependent: signed overflow for ADD, but unsigned borrow for SUB.
  always_comb begin
    ovf = 1'b0;
    unique case (alu_op_e'(op_i))
      ALU_ADD: ovf = (a_msb_i == b_msb_i) && (res_i[W-1] != a_msb_i);
      ALU_SUB: ovf = borrow_i;
      ALU_AND: ovf = 1'b0;
      ALU_NOT: ovf = 1'b0;
    endcase
  end

  always_comb begin
    z_o         = '0;
    z_o[Z_ZERO] = ~|res_i;
    z_o[Z_NEG]  = res_i[W-1];
    z_o[Z_OVF]  = ovf;
  end

endmodule

// File: rtl/alu_core.sv
// 16-bit two-operand ALU with combinational result/status and a registered status copy.
// Define ALU_STICKY_OVF_EN to add the ovf_sticky output, set by any overflow capture until reset.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  input  logic [1:0]   ALUop,
  input  logic         status_en,
  output logic [W-1:0] out,
  output logic [2:0]   Z,
  output logic [2:0]   Z_q
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic         ovf_sticky
`endif
);

  logic [W-1:0] sum;
  logic [W:0]   diff_ext;
  logic [W-1:0] res;
  logic [2:0]   status_d;
  logic [2:0]   status_q;

  assign sum      = Ain + Bin;
  // Extra MSB of the zero-extended subtraction is the unsigned borrow (Ain < Bin).
  assign diff_ext = {1'b0, Ain} - {1'b0, Bin};

  always_comb begin
    res = '0;
    unique case (alu_op_e'(ALUop))
      ALU_ADD: res = sum;
      ALU_SUB: res = diff_ext[W-1:0];
      ALU_AND: res = Ain & Bin;
      ALU_NOT: res = ~Bin;
    endcase
  end

  alu_flags #(
    .W(W)
  ) u_flags (
    .res_i   (res),
    .a_msb_i (Ain[W-1]),
    .b_msb_i (Bin[W-1]),
    .borrow_i(diff_ext[W]),
    .op_i    (ALUop),
    .z_o     (status_d)
  );

  assign out = res;
  assign Z   = status_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q <= '0;
    end else if (status_en) begin
      status_q <= status_d;
    end
  end

  assign Z_q = status_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else if (status_en && status_d[Z_OVF]) begin
      sticky_q <= 1'b1;
    end
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: directed vectors queue expected values, a negedge monitor checks them.
module tb_alu_core;

  logic        clk;
  logic        reset;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [1:0]  ALUop;
  logic        status_en;
  logic [15:0] out;
  logic [2:0]  Z;
  logic [2:0]  Z_q;
`ifdef ALU_STICKY_OVF_EN
  logic        ovf_sticky;
`endif

  alu_core #(
    .W(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Ain      (Ain),
    .Bin      (Bin),
    .ALUop    (ALUop),
    .status_en(status_en),
    .out      (out),
    .Z        (Z),
    .Z_q      (Z_q)
`ifdef ALU_STICKY_OVF_EN
    ,
    .ovf_sticky(ovf_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_out;
    logic [2:0]  exp_z;
    logic [2:0]  exp_zq;
    logic        exp_st;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   tests  = 0;
  int   fails  = 0;
  bit   done   = 1'b0;

  task automatic add(input logic r, input logic e, input logic [1:0] op,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] o, input logic [2:0] z,
                     input logic [2:0] zq, input logic st);
    vec_t v;
    v.rst = r; v.en = e; v.op = op; v.a = a; v.b = b;
    v.exp_out = o; v.exp_z = z; v.exp_zq = zq; v.exp_st = st;
    vecs.push_back(v);
  endtask

  // Stimulus: each vector applied #1 after a rising edge; exp_zq/exp_st are values before that cycle's edge.
  initial begin
    reset = 1'b1; status_en = 1'b0; Ain = '0; Bin = '0; ALUop = 2'b00;
    //   rst  en   op     A        B        out      Z       Z_q     sticky
    add(1'b1, 1'b0, 2'b00, 16'h0001, 16'h0003, 16'h0004, 3'b000, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b01, 16'h0003, 16'h0001, 16'h0002, 3'b000, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b10, 16'h0003, 16'h0001, 16'h0001, 3'b000, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b11, 16'h0003, 16'h0001, 16'hFFFE, 3'b010, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b10, 16'hFFFF, 16'h0000, 16'h0000, 3'b001, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b01, 16'h0001, 16'h0001, 16'h0000, 3'b001, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 3'b110, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b00, 16'h8000, 16'h8000, 16'h0000, 3'b101, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b00, 16'h7FFF, 16'h7FFF, 16'hFFFE, 3'b110, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 3'b110, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 3'b010, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b01, 16'h8000, 16'h0001, 16'h7FFF, 3'b000, 3'b000, 1'b0);
    add(1'b0, 1'b1, 2'b01, 16'h0001, 16'h0001, 16'h0000, 3'b001, 3'b000, 1'b0);
    add(1'b0, 1'b0, 2'b00, 16'h7FFF, 16'h7FFF, 16'hFFFE, 3'b110, 3'b001, 1'b0);
    add(1'b1, 1'b1, 2'b00, 16'h8000, 16'h8000, 16'h0000, 3'b101, 3'b001, 1'b0);
    add(1'b0, 1'b0, 2'b00, 16'h0001, 16'h0003, 16'h0004, 3'b000, 3'b000, 1'b0);
    add(1'b0, 1'b1, 2'b00, 16'h8000, 16'h8000, 16'h0000, 3'b101, 3'b000, 1'b0);
    add(1'b0, 1'b1, 2'b00, 16'h0001, 16'h0003, 16'h0004, 3'b000, 3'b101, 1'b1);
    add(1'b0, 1'b0, 2'b01, 16'h0000, 16'h0001, 16'hFFFF, 3'b110, 3'b000, 1'b1);
    add(1'b1, 1'b0, 2'b10, 16'h0003, 16'h0001, 16'h0001, 3'b000, 3'b000, 1'b1);
    add(1'b0, 1'b0, 2'b00, 16'h0001, 16'h0003, 16'h0004, 3'b000, 3'b000, 1'b0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; status_en = vecs[i].en; ALUop = vecs[i].op;
      Ain = vecs[i].a; Bin = vecs[i].b;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
    end
    reset = 1'b0; status_en = 1'b0;
    done = 1'b1;
  end

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so each queued vector is checked at the following falling edge.
  initial begin
    vec_t e;
    int   n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (out !== e.exp_out) begin
          fails++;
          $display("FAIL out[%0d]: got %h expected %h", n, out, e.exp_out);
        end
        chk3($sformatf("Z[%0d]", n), Z, e.exp_z);
        chk3($sformatf("Z_q[%0d]", n), Z_q, e.exp_zq);
`ifdef ALU_STICKY_OVF_EN
        tests++;
        if (ovf_sticky !== e.exp_st) begin
          fails++;
          $display("FAIL ovf_sticky[%0d]: got %b expected %b", n, ovf_sticky, e.exp_st);
        end
`endif
        n++;
      end
    end
  end

  initial begin
    fork
      begin
        wait (done);
        repeat (3) @(posedge clk);
      end
      begin
        #100000;
        fails++;
        $display("FAIL timeout: got no completion expected completion");
      end
    join_any
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
